spi_byte_master: RTL and testbench
==================================

# spi_byte_master

Byte-oriented SPI master that sits directly downstream of the test-constant generator and the sensor data sources. It captures an 8-bit word on each rising edge of START, queues it in a 4-entry FIFO, and shifts it out MSB-first in SPI mode 0 at CLK_1KHZ/2. It simultaneously captures the slave's MISO byte and presents it with a one-cycle valid strobe.

## Interface
- No parameters. FIFO depth is fixed at 4 and word width at 8.
- CLK_1KHZ  input  1  system clock; all state changes on its rising edge
- RESET  input  1  asynchronous, active-high reset
- DATA  input  8  word to transmit; sampled on the START rising-edge cycle
- START  input  1  level input; each 0→1 transition requests one byte
- MISO  input  1  serial data from slave
- SCLK  output  1  SPI clock, idle low
- MOSI  output  1  serial data to slave, MSB first
- CS_N  output  1  chip select, active low, asserted per byte
- RX_DATA  output  8  last byte received on MISO
- RX_VALID  output  1  one-cycle pulse when RX_DATA updates
- BUSY  output  1  high whenever state ≠ IDLE or FIFO_LEVEL ≠ 0
- OVERFLOW  output  1  sticky flag: a START edge was dropped; cleared only by RESET
- FIFO_LEVEL  output  3  number of queued bytes, 0..4

## Operation
- Reset values: SCLK=0, MOSI=0, CS_N=1, RX_DATA=0, RX_VALID=0, BUSY=0, OVERFLOW=0, FIFO_LEVEL=0. The START history register, FIFO pointers, bit counter and shift register all reset to 0. State resets to IDLE.
- Edge detect: START_d is START registered. A push request occurs on an edge where START=1 and START_d=0. DATA is written on that same edge.
- Push rule: a push is accepted when FIFO_LEVEL<4, or when a pop occurs on the same edge. Otherwise the byte is dropped and OVERFLOW is set to 1. The FIFO contents and level are unchanged on a drop.
- Simultaneous push and pop: the level is unchanged, the pop returns the oldest entry, and the new entry is appended.
- Pointers are 2-bit and wrap 3→0.
- States:
  - IDLE: CS_N=1, SCLK=0, MOSI=0. If FIFO_LEVEL>0, pop into the shift register, set bit counter=7 and phase=0, and go to SHIFT.
  - SHIFT: CS_N=0 and MOSI=shreg[7].
    - Phase 0: SCLK=0.
    - Phase 1: SCLK=1. On the edge ending phase 1, shreg shifts left with MISO inserted at bit 0.
    - If the bit counter=0, go to GAP. Otherwise decrement the counter and return to phase 0.
  - GAP: one cycle with CS_N=1, SCLK=0, MOSI=0, RX_DATA equal to the received byte, and RX_VALID=1. The next state is always IDLE.
- Reset mid-byte: all outputs return immediately (asynchronously) to their reset values. The FIFO is emptied and no partial byte is reported.

## Timing
- Let capture edge E be the edge that writes the FIFO while the block is IDLE and the FIFO is empty.
  - After E+1: CS_N=0, MOSI=bit7, SCLK=0.
  - After E+2: SCLK=1.
  - SCLK toggles every cycle from there.
  - The bit-n high phase follows edge E+2+2·(7−n).
- After E+17: CS_N=1, RX_VALID=1, and RX_DATA holds the new byte.
- After E+18: state is IDLE and RX_VALID=0. The earliest next pop is at edge E+19.
- CS_N is low for exactly 16 cycles per byte. The pop-to-pop period is 18 cycles.
- FIFO_LEVEL is registered and reflects pushes and pops one edge after they occur.
- OVERFLOW rises on the edge of the dropped push.

## Test plan
- Reset: hold RESET high, then release it → all outputs at their reset values and no SCLK activity with START held at 0.
- Single byte: DATA=0xA5, pulse START once, MISO driven as 0x3C (slave changes MISO on SCLK falling edge) → MOSI bits 1,0,1,0,0,1,0,1 across 8 SCLK pulses. CS_N is low for 16 cycles. RX_DATA=0x3C with RX_VALID high for exactly one cycle at E+17.
- Queue fill: drive the generator pattern (START toggles every cycle, DATA increments 0x01,0x02,...) for 10 cycles → 5 rising edges, 4 bytes queued. The first is popped at E+1, so no drop occurs. Bytes are sent in order with CS_N deasserted for 2 cycles between bytes.
- Overflow: 6 START edges at 2-cycle spacing while SHIFT is busy → FIFO_LEVEL saturates at 4, OVERFLOW=1, and the extra byte never appears on MOSI. OVERFLOW stays at 1 after the FIFO drains.
- Full with simultaneous pop: FIFO_LEVEL=4 and a START edge coincides with the IDLE pop edge → push is accepted, FIFO_LEVEL stays at 4, and no OVERFLOW.
- Reset mid-operation: assert RESET after the 3rd SCLK pulse of a byte → CS_N=1, SCLK=0, FIFO_LEVEL=0 and RX_VALID=0 immediately. After release, no further SCLK activity without a new START edge.

Source files
------------

// File: rtl/spi_byte_master.sv
// Byte SPI master (mode 0, SCLK = CLK_1KHZ/2) with a 4-deep transmit FIFO and MISO capture.
// Latency: CS_N falls one edge after a byte lands in an empty FIFO; RX_VALID pulses 17 edges after that capture.
// Backpressure: none upstream; a START edge that finds the FIFO full (and no same-edge pop) is dropped and OVERFLOW sticks.
`timescale 1ns/1ps
module spi_byte_master (
  input  logic       CLK_1KHZ,
  input  logic       RESET,
  input  logic [7:0] DATA,
  input  logic       START,
  input  logic       MISO,
  output logic       SCLK,
  output logic       MOSI,
  output logic       CS_N,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       BUSY,
  output logic       OVERFLOW,
  output logic [2:0] FIFO_LEVEL
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t      state_q, state_d;
  logic        phase_q, phase_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        start_q, start_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  level_q, level_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic [7:0]  mem_q [4];
  logic [7:0]  mem_d [4];

  logic push_req;
  logic pop;
  logic push_ok;

  // All state registers, cleared asynchronously so outputs drop to idle values at once.
  always_ff @(posedge CLK_1KHZ or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      phase_q   <= 1'b0;
      cnt_q     <= 3'd0;
      shreg_q   <= 8'd0;
      start_q   <= 1'b0;
      wr_ptr_q  <= 2'd0;
      rd_ptr_q  <= 2'd0;
      level_q   <= 3'd0;
      ovf_q     <= 1'b0;
      rx_data_q <= 8'd0;
      for (int i = 0; i < 4; i++) mem_q[i] <= 8'd0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      start_q   <= start_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      rx_data_q <= rx_data_d;
      for (int i = 0; i < 4; i++) mem_q[i] <= mem_d[i];
    end
  end

  // FIFO push/pop bookkeeping; a pop on the same edge frees the slot a full-FIFO push needs.
  always_comb begin
    start_d  = START;
    push_req = START & ~start_q;
    pop      = (state_q == IDLE) && (level_q != 3'd0);
    push_ok  = push_req && ((level_q != 3'd4) || pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    for (int i = 0; i < 4; i++) mem_d[i] = mem_q[i];

    if (push_ok) begin
      mem_d[wr_ptr_q] = DATA;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end else if (push_req) begin
      ovf_d = 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;

    unique case ({push_ok, pop})
      2'b10:   level_d = level_q + 3'd1;
      2'b01:   level_d = level_q - 3'd1;
      default: level_d = level_q;
    endcase
  end

  // Byte sequencer: pop in IDLE, 8 two-cycle bit periods in SHIFT, one reporting cycle in GAP.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    rx_data_d = rx_data_q;

    unique case (state_q)
      IDLE: begin
        if (level_q != 3'd0) begin
          shreg_d = mem_q[rd_ptr_q];
          cnt_d   = 3'd7;
          phase_d = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          // Falling SCLK edge: MISO is sampled as the shift register advances.
          phase_d = 1'b0;
          shreg_d = {shreg_q[6:0], MISO};
          if (cnt_q == 3'd0) begin
            rx_data_d = {shreg_q[6:0], MISO};
            state_d   = GAP;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Serial pins decode straight from state so reset forces them idle without waiting for a clock.
  always_comb begin
    CS_N       = (state_q != SHIFT);
    SCLK       = (state_q == SHIFT) && phase_q;
    MOSI       = (state_q == SHIFT) && shreg_q[7];
    RX_VALID   = (state_q == GAP);
    RX_DATA    = rx_data_q;
    BUSY       = (state_q != IDLE) || (level_q != 3'd0);
    OVERFLOW   = ovf_q;
    FIFO_LEVEL = level_q;
  end

endmodule

// File: tb/tb_spi_byte_master.sv
`timescale 1ns/1ps
module tb_spi_byte_master;

  logic       CLK_1KHZ = 1'b0;
  logic       RESET    = 1'b1;
  logic [7:0] DATA     = 8'd0;
  logic       START    = 1'b0;
  logic       MISO     = 1'b0;
  logic       SCLK, MOSI, CS_N, RX_VALID, BUSY, OVERFLOW;
  logic [7:0] RX_DATA;
  logic [2:0] FIFO_LEVEL;

  spi_byte_master dut (
    .CLK_1KHZ(CLK_1KHZ), .RESET(RESET), .DATA(DATA), .START(START), .MISO(MISO),
    .SCLK(SCLK), .MOSI(MOSI), .CS_N(CS_N), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .BUSY(BUSY), .OVERFLOW(OVERFLOW), .FIFO_LEVEL(FIFO_LEVEL)
  );

  always #5 CLK_1KHZ = ~CLK_1KHZ;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_tx_q[$];
  logic [7:0] exp_rx_q[$];
  logic [7:0] miso_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected transmit byte plus the pattern the slave will return for it.
  task automatic expect_byte(input logic [7:0] tx, input logic [7:0] rx);
    exp_tx_q.push_back(tx);
    exp_rx_q.push_back(rx);
    miso_q.push_back(rx);
  endtask

  // One START pulse: high for one cycle, low for one; called at a negedge.
  task automatic push_byte(input logic [7:0] d, input bit accepted);
    START = 1'b1;
    DATA  = d;
    if (accepted) expect_byte(d, ~d);
    @(negedge CLK_1KHZ);
    START = 1'b0;
    @(negedge CLK_1KHZ);
  endtask

  task automatic wait_idle(input string name, input int limit);
    bit ok = 1'b0;
    for (int t = 0; t < limit; t++) begin
      @(negedge CLK_1KHZ);
      if (!BUSY) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  // Slave model: presents bit 7 when selected, then advances on each SCLK fall.
  logic [7:0] s_byte = 8'd0;
  int         s_idx  = 0;
  bit         s_act  = 1'b0;
  bit         s_prev_sclk = 1'b0;
  always @(negedge CLK_1KHZ) begin
    if (RESET) begin
      s_act = 1'b0;
      MISO  = 1'b0;
    end else if (!CS_N && !s_act) begin
      s_act  = 1'b1;
      s_byte = (miso_q.size() != 0) ? miso_q.pop_front() : 8'h00;
      MISO   = s_byte[7];
      s_idx  = 6;
    end else if (!CS_N && s_prev_sclk && !SCLK) begin
      if (s_idx >= 0) MISO = s_byte[s_idx];
      s_idx--;
    end else if (CS_N) begin
      s_act = 1'b0;
    end
    s_prev_sclk = SCLK;
  end

  // Monitor: collects MOSI on SCLK rises and scores each byte when RX_VALID appears.
  int         cs_cnt = 0, bit_cnt = 0, hi_cnt = 0;
  logic [7:0] tx_acc = 8'd0;
  bit         m_prev_sclk = 1'b0;
  bit         b2b = 1'b0;
  always @(negedge CLK_1KHZ) begin
    if (RESET) begin
      cs_cnt = 0; bit_cnt = 0; hi_cnt = 0; tx_acc = 8'd0; b2b = 1'b0;
    end else begin
      if (RX_VALID) begin
        check("rx_expected_pending", (exp_tx_q.size() != 0), 1);
        if (exp_tx_q.size() != 0) begin
          check("mosi_byte", tx_acc, exp_tx_q.pop_front());
          check("rx_data", RX_DATA, exp_rx_q.pop_front());
          check("cs_low_cycles", cs_cnt, 16);
          check("sclk_pulses", bit_cnt, 8);
          check("cs_high_in_gap", CS_N, 1);
        end
        b2b = (FIFO_LEVEL != 3'd0);
        cs_cnt = 0; bit_cnt = 0; hi_cnt = 0;
      end
      if (!CS_N) begin
        if (cs_cnt == 0 && b2b) begin
          check("inter_byte_gap", hi_cnt, 2);
          b2b = 1'b0;
        end
        cs_cnt++;
        if (SCLK && !m_prev_sclk) begin
          tx_acc = {tx_acc[6:0], MOSI};
          bit_cnt++;
        end
      end else begin
        hi_cnt++;
      end
    end
    m_prev_sclk = SCLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit quiet;
    int n;

    // Reset values while held in reset.
    RESET = 1'b1;
    repeat (3) @(negedge CLK_1KHZ);
    check("rst_sclk", SCLK, 0);
    check("rst_mosi", MOSI, 0);
    check("rst_cs_n", CS_N, 1);
    check("rst_rx_data", RX_DATA, 8'h00);
    check("rst_rx_valid", RX_VALID, 0);
    check("rst_busy", BUSY, 0);
    check("rst_overflow", OVERFLOW, 0);
    check("rst_level", FIFO_LEVEL, 0);
    RESET = 1'b0;
    quiet = 1'b1;
    repeat (10) begin
      @(negedge CLK_1KHZ);
      if (SCLK || !CS_N || BUSY) quiet = 1'b0;
    end
    check("idle_after_reset", quiet, 1);

    // Single byte 0xA5 with slave returning 0x3C, cycle-exact checks.
    START = 1'b1;
    DATA  = 8'hA5;
    exp_tx_q.push_back(8'hA5); exp_rx_q.push_back(8'h3C); miso_q.push_back(8'h3C);
    @(negedge CLK_1KHZ);                       // after E
    START = 1'b0;
    check("e0_level", FIFO_LEVEL, 1);
    check("e0_cs_n", CS_N, 1);
    @(negedge CLK_1KHZ);                       // after E+1
    check("e1_cs_n", CS_N, 0);
    check("e1_sclk", SCLK, 0);
    check("e1_mosi_bit7", MOSI, 1);
    check("e1_level", FIFO_LEVEL, 0);
    @(negedge CLK_1KHZ);                       // after E+2
    check("e2_sclk", SCLK, 1);
    repeat (14) @(negedge CLK_1KHZ);           // after E+16
    check("e16_rx_valid", RX_VALID, 0);
    check("e16_cs_n", CS_N, 0);
    @(negedge CLK_1KHZ);                       // after E+17
    check("e17_rx_valid", RX_VALID, 1);
    check("e17_cs_n", CS_N, 1);
    check("e17_rx_data", RX_DATA, 8'h3C);
    @(negedge CLK_1KHZ);                       // after E+18
    check("e18_rx_valid", RX_VALID, 0);
    check("e18_busy", BUSY, 0);
    check("e18_rx_data_held", RX_DATA, 8'h3C);

    // Generator pattern: START toggles each cycle, DATA counts up; edges carry 01,03,05,07,09.
    for (int i = 0; i < 10; i++) begin
      START = (i % 2 == 0);
      DATA  = 8'(i + 1);
      if (i % 2 == 0) expect_byte(8'(i + 1), ~8'(i + 1));
      @(negedge CLK_1KHZ);
    end
    START = 1'b0;
    check("fill_level", FIFO_LEVEL, 4);
    check("fill_no_overflow", OVERFLOW, 0);
    wait_idle("fill_drain", 200);

    // Full FIFO with a push landing on the IDLE pop edge.
    push_byte(8'h11, 1'b1);
    push_byte(8'h22, 1'b1);
    push_byte(8'h33, 1'b1);
    push_byte(8'h44, 1'b1);
    push_byte(8'h55, 1'b1);
    check("full_level", FIFO_LEVEL, 4);
    n = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge CLK_1KHZ);
      if (RX_VALID) begin
        n = 1;
        break;
      end
    end
    check("full_gap_seen", n, 1);
    @(negedge CLK_1KHZ);                       // IDLE cycle before the pop edge
    check("full_level_pre_pop", FIFO_LEVEL, 4);
    START = 1'b1;
    DATA  = 8'h66;
    expect_byte(8'h66, ~8'h66);
    @(negedge CLK_1KHZ);
    START = 1'b0;
    check("full_simul_level", FIFO_LEVEL, 4);
    check("full_simul_no_overflow", OVERFLOW, 0);
    wait_idle("full_drain", 300);

    // Overflow: six edges during one byte; the last two are dropped.
    push_byte(8'hA1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      push_byte(8'hB0 + 8'(k), (k < 4));
      check("ovf_progress", OVERFLOW, (k >= 4));
    end
    check("ovf_level", FIFO_LEVEL, 4);
    wait_idle("ovf_drain", 300);
    check("ovf_sticky", OVERFLOW, 1);
    check("ovf_drained_level", FIFO_LEVEL, 0);

    // Reset after the third SCLK pulse of a byte, with another byte queued.
    START = 1'b1;
    DATA  = 8'hC3;
    expect_byte(8'hC3, ~8'hC3);
    @(negedge CLK_1KHZ);
    START = 1'b0;
    n = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge CLK_1KHZ);
      if (t == 0) begin
        START = 1'b1;
        DATA  = 8'hD4;
        expect_byte(8'hD4, ~8'hD4);
      end else begin
        START = 1'b0;
      end
      if (SCLK) n++;
      if (n == 3) break;
    end
    START = 1'b0;
    check("mid_pulses_seen", n, 3);
    @(negedge CLK_1KHZ);
    check("mid_level_before_reset", FIFO_LEVEL, 1);
    check("mid_cs_low_before_reset", CS_N, 0);
    RESET = 1'b1;
    #1;
    check("mid_rst_cs_n", CS_N, 1);
    check("mid_rst_sclk", SCLK, 0);
    check("mid_rst_mosi", MOSI, 0);
    check("mid_rst_level", FIFO_LEVEL, 0);
    check("mid_rst_rx_valid", RX_VALID, 0);
    check("mid_rst_overflow", OVERFLOW, 0);
    check("mid_rst_busy", BUSY, 0);
    exp_tx_q.delete();
    exp_rx_q.delete();
    miso_q.delete();
    @(negedge CLK_1KHZ);
    RESET = 1'b0;
    quiet = 1'b1;
    repeat (40) begin
      @(negedge CLK_1KHZ);
      if (SCLK || !CS_N || RX_VALID || BUSY) quiet = 1'b0;
    end
    check("mid_quiet_after_release", quiet, 1);

    check("scoreboard_empty", exp_tx_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
